// File: rtl/bcd_event_counter.sv
// bcd_event_counter: debounced up/down BCD event counter with multiplexed seven-segment display
module bcd_event_counter #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 1024,
  parameter int DEB_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  cou,
  input  logic                  up_dn,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   bcd_value,
  output logic                  ovf,
  output logic [DIGITS-1:0]     digit_en,
  output logic [7:0]            digit_seg
);
  localparam int DW = $clog2(DEB_CYCLES) + 1;
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

  logic                s1_q, s2_q, deb_q, deb_dly_q;
  logic [DW-1:0]       dcnt_q;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, carry, pulse, tc, blank;
  logic [PW-1:0]       pre_q;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   en_q, nz;
  logic [7:0]          seg_q, seg_d;
  logic [3:0]          cur;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: seg7 = 8'hFC;
      4'd1: seg7 = 8'h60;
      4'd2: seg7 = 8'hDA;
      4'd3: seg7 = 8'hF2;
      4'd4: seg7 = 8'h66;
      4'd5: seg7 = 8'hB6;
      4'd6: seg7 = 8'hBE;
      4'd7: seg7 = 8'hE0;
      4'd8: seg7 = 8'hFE;
      4'd9: seg7 = 8'hF6;
      default: seg7 = 8'h00;
    endcase
  endfunction

  assign pulse = deb_q & ~deb_dly_q;
  assign tc    = pre_q == PW'(SCAN_DIV - 1);
  assign idx_d = idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;

  // Ripple carry/borrow: a digit only moves while every lower digit wrapped.
  always_comb begin
    bcd_d = bcd_q;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry)
        bcd_d[4*i+:4] = up_dn ? (bcd_q[4*i+:4] == 4'd9 ? 4'd0 : bcd_q[4*i+:4] + 4'd1)
                              : (bcd_q[4*i+:4] == 4'd0 ? 4'd9 : bcd_q[4*i+:4] - 4'd1);
      carry = carry & (bcd_q[4*i+:4] == (up_dn ? 4'd9 : 4'd0));
    end
  end

  // nz[i] is set when digit i or any higher digit is non-zero.
  always_comb begin
    nz    = '0;
    cur   = '0;
    blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      nz[i] = |(bcd_q >> (4*i));
      if (idx_d == IW'(i)) begin
        cur   = bcd_q[4*i+:4];
        blank = (i != 0) && !nz[i];
      end
    end
    seg_d = blank ? 8'h00 : seg7(cur);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      dcnt_q    <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      pre_q     <= '0;
      idx_q     <= '0;
      en_q      <= DIGITS'(1);
      seg_q     <= 8'hFC;
    end else begin
      s1_q      <= cou;
      s2_q      <= s1_q;
      deb_dly_q <= deb_q;
      if (s2_q == deb_q) dcnt_q <= '0;
      else if (dcnt_q == DW'(DEB_CYCLES - 1)) begin
        deb_q  <= s2_q;
        dcnt_q <= '0;
      end else dcnt_q <= dcnt_q + 1'b1;
      if (clr) begin
        bcd_q <= '0;
        ovf_q <= 1'b0;
      end else if (pulse) begin
        bcd_q <= bcd_d;
        ovf_q <= ovf_q | carry;
      end
      pre_q <= tc ? '0 : pre_q + 1'b1;
      if (tc) begin
        idx_q <= idx_d;
        en_q  <= DIGITS'(1) << idx_d;
        seg_q <= seg_d;
      end
    end
  end

  assign bcd_value = bcd_q;
  assign ovf       = ovf_q;
  assign digit_en  = en_q;
  assign digit_seg = seg_q;
endmodule
